term_controller: RTL

TERM_CONTROLLER -- requirements
Module: term_controller

---
 rtl/term_pkg.sv | 43 ++++
 rtl/term_controller_cursor_blinker.sv | 32 +++
 rtl/term_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/term_pkg.sv
// Shared constants, FSM state type and buffer-address helper for the
// character-terminal controller.
package term_pkg;

    localparam int TERM_COLS     = 80;
    localparam int TERM_ROWS     = 25;
    localparam int TERM_BUF_SIZE = 2000;

    // Buffer index width and the wider width used for unreduced sums.
    localparam int ADDR_W = 11;
    localparam int CALC_W = 12;

    // Control codes and the fill character used when clearing.
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] SPACE = 8'h20;

    // First and last printable codes.
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_ROW,
        CLEAR_ALL
    } term_state_t;

    // Adds two buffer offsets and folds the result back into 0..1999.
    // Callers keep both operands small enough that the 12-bit sum stays
    // below 4000, so one conditional subtraction is always sufficient.
    function automatic logic [ADDR_W-1:0] wrap_add(input logic [CALC_W-1:0] a,
                                                   input logic [CALC_W-1:0] b);
        logic [CALC_W-1:0] sum;
        sum = a + b;
        if (sum >= CALC_W'(TERM_BUF_SIZE)) begin
            sum = sum - CALC_W'(TERM_BUF_SIZE);
        end
        return sum[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/term_controller_cursor_blinker.sv
// Cursor blink generator: blink_on starts high and inverts every
// BLINK_HALF_PERIOD clock cycles. Only instantiated when the build defines
// TERM_CURSOR_BLINK_EN.
module cursor_blinker #(
    parameter int BLINK_HALF_PERIOD = 12000000
) (
    input  logic clk,
    input  logic reset,
    output logic blink_on
);

    localparam int CNT_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_HALF_PERIOD - 1);

    logic [CNT_W-1:0] count;

    // Count one half-period, then flip the phase and restart the count.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            blink_on <= 1'b1;
        end else if (count == LAST) begin
            count    <= '0;
            blink_on <= ~blink_on;
        end else begin
            count    <= count + 1'b1;
        end
    end

endmodule

// File: rtl/term_controller.sv
// Character-terminal controller: consumes host bytes, writes printable
// characters into a 2000-cell circular character buffer, tracks the cursor
// and scroll origin, and performs row/screen clears.
// Build option: define TERM_CURSOR_BLINK_EN to enable the cursor blinker;
// otherwise cursor_blink_on is tied high and no counter exists.
module term_controller
    import term_pkg::*;
#(
    parameter int BLINK_HALF_PERIOD = 12000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              cursor_blink_on,
    output logic [ADDR_W-1:0] first_char
);

    localparam logic [6:0]        LAST_COL      = 7'(TERM_COLS - 1);
    localparam logic [4:0]        LAST_ROW      = 5'(TERM_ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST_IDX  = ADDR_W'(TERM_COLS - 1);
    localparam logic [ADDR_W-1:0] BUF_LAST_IDX  = ADDR_W'(TERM_BUF_SIZE - 1);
    localparam logic [CALC_W-1:0] BOTTOM_OFFSET = CALC_W'((TERM_ROWS - 1) * TERM_COLS);

    term_state_t       state, nxt_state;
    logic [ADDR_W-1:0] clear_count, nxt_count;
    logic              nxt_wr_en;
    logic [ADDR_W-1:0] nxt_wr_addr;
    logic [7:0]        nxt_wr_data;
    logic [6:0]        nxt_x;
    logic [4:0]        nxt_y;
    logic [ADDR_W-1:0] nxt_first;
    logic              do_lf;
    logic              printable;
    logic [ADDR_W-1:0] cell_addr;
    logic [ADDR_W-1:0] row_base;

    assign in_ready  = (state == IDLE);
    assign printable = (in_data >= PRINT_LO) && (in_data <= PRINT_HI);

    // Buffer cell under the cursor. first_char <= 1920 and y*80+x <= 1999,
    // so the 12-bit sum never exceeds 3919.
    assign cell_addr = wrap_add(CALC_W'(first_char),
                                CALC_W'(cursor_y) * CALC_W'(TERM_COLS) + CALC_W'(cursor_x));

    // Start of the bottom visible row; first_char already holds the scrolled
    // origin while CLEAR_ROW runs.
    assign row_base = wrap_add(CALC_W'(first_char), BOTTOM_OFFSET);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state, cursor and write-port decode.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt_state   = state;
        nxt_count   = clear_count;
        nxt_wr_en   = 1'b0;
        nxt_wr_addr = wr_addr;
        nxt_wr_data = wr_data;
        nxt_x       = cursor_x;
        nxt_y       = cursor_y;
        nxt_first   = first_char;
        do_lf       = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (printable) begin
                        nxt_wr_en   = 1'b1;
                        nxt_wr_addr = cell_addr;
                        nxt_wr_data = in_data;
                        if (cursor_x == LAST_COL) begin
                            nxt_x = '0;
                            do_lf = 1'b1;
                        end else begin
                            nxt_x = cursor_x + 7'd1;
                        end
                    end else begin
                        case (in_data)
                            CR: nxt_x = '0;
                            LF: do_lf = 1'b1;
                            BS: begin
                                if (cursor_x != '0) begin
                                    nxt_x = cursor_x - 7'd1;
                                end
                            end
                            FF: begin
                                nxt_x     = '0;
                                nxt_y     = '0;
                                nxt_first = '0;
                                nxt_count = '0;
                                nxt_state = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end

                    // Line feed: move down, or scroll the origin by one row
                    // and blank the row that becomes the bottom line.
                    if (do_lf) begin
                        if (cursor_y != LAST_ROW) begin
                            nxt_y = cursor_y + 5'd1;
                        end else begin
                            nxt_first = wrap_add(CALC_W'(first_char), CALC_W'(TERM_COLS));
                            nxt_count = '0;
                            nxt_state = CLEAR_ROW;
                        end
                    end
                end
            end

            CLEAR_ROW: begin
                nxt_wr_en   = 1'b1;
                nxt_wr_data = SPACE;
                nxt_wr_addr = wrap_add(CALC_W'(row_base), CALC_W'(clear_count));
                if (clear_count == ROW_LAST_IDX) begin
                    nxt_state = IDLE;
                end else begin
                    nxt_count = clear_count + 1'b1;
                end
            end

            CLEAR_ALL: begin
                nxt_wr_en   = 1'b1;
                nxt_wr_data = SPACE;
                nxt_wr_addr = clear_count;
                if (clear_count == BUF_LAST_IDX) begin
                    nxt_state = IDLE;
                end else begin
                    nxt_count = clear_count + 1'b1;
                end
            end

            default: nxt_state = IDLE;
        endcase
    end

    // Datapath registers: write port, cursor, scroll origin, clear counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cursor_x    <= '0;
            cursor_y    <= '0;
            first_char  <= '0;
            clear_count <= '0;
        end else begin
            wr_en       <= nxt_wr_en;
            wr_addr     <= nxt_wr_addr;
            wr_data     <= nxt_wr_data;
            cursor_x    <= nxt_x;
            cursor_y    <= nxt_y;
            first_char  <= nxt_first;
            clear_count <= nxt_count;
        end
    end

`ifdef TERM_CURSOR_BLINK_EN
    cursor_blinker #(
        .BLINK_HALF_PERIOD(BLINK_HALF_PERIOD)
    ) u_blinker (
        .clk      (clk),
        .reset    (reset),
        .blink_on (cursor_blink_on)
    );
`else
    // Steady cursor; the parameter term folds to 0, so the output stays 1.
    assign cursor_blink_on = 1'b1 | (BLINK_HALF_PERIOD < 0);
`endif

endmodule
